// File: rtl/game_if.sv
// Handshake bundle between the game controller and its input/collision and display neighbours.
interface game_if;
  logic       start;
  logic       p1_hits;
  logic       p2_hits;
  logic [2:0] game_state;
  logic [2:0] p1_health;
  logic [2:0] p2_health;
  logic [6:0] seconds_left;
  logic       tick;

  modport master (
    output start, p1_hits, p2_hits,
    input  game_state, p1_health, p2_health, seconds_left, tick
  );

  modport slave (
    input  start, p1_hits, p2_hits,
    output game_state, p1_health, p2_health, seconds_left, tick
  );
endinterface

// File: rtl/game_controller.sv
// Match phase FSM for the two-player fighting game: owns phase, both health values
// and the per-phase seconds counter driven by a one-second prescaler.
module game_controller #(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned COUNTDOWN_S = 3,
  parameter int unsigned FIGHT_S     = 60,
  parameter int unsigned RESULT_S    = 5,
  parameter int unsigned MAX_HEALTH  = 3
) (
  input  logic   clk,
  input  logic   rst,
  game_if.slave  bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HW = 3;
  localparam int unsigned SW = 7;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_FIGHT     = 3'd2,
    S_P1_WIN    = 3'd3,
    S_P2_WIN    = 3'd4,
    S_EQ        = 3'd5
  } state_t;

  state_t          r_state;
  logic [HW-1:0]   r_p1_health;
  logic [HW-1:0]   r_p2_health;
  logic [SW-1:0]   r_seconds;
  logic [PW-1:0]   r_presc;
  logic            r_tick;
  logic            r_start_q;

  state_t          w_state_nxt;
  logic [HW-1:0]   w_p1_nxt;
  logic [HW-1:0]   w_p2_nxt;
  logic [SW-1:0]   w_seconds_nxt;
  logic [PW-1:0]   w_presc_nxt;
  logic            w_start_rise;
  logic            w_timed;
  logic            w_wrap;
  logic            w_last;
  logic [HW-1:0]   w_p1_post;
  logic [HW-1:0]   w_p2_post;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_p1_health <= HW'(MAX_HEALTH);
      r_p2_health <= HW'(MAX_HEALTH);
      r_seconds   <= '0;
      r_presc     <= '0;
      r_tick      <= 1'b0;
      r_start_q   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_p1_health <= w_p1_nxt;
      r_p2_health <= w_p2_nxt;
      r_seconds   <= w_seconds_nxt;
      r_presc     <= w_presc_nxt;
      r_tick      <= w_wrap;
      r_start_q   <= bus.start;
    end
  end

  // Next-state, health, seconds and prescaler logic
  always_comb begin
    w_state_nxt   = r_state;
    w_p1_nxt      = r_p1_health;
    w_p2_nxt      = r_p2_health;
    w_seconds_nxt = r_seconds;
    w_presc_nxt   = '0;

    w_start_rise = bus.start & ~r_start_q;
    w_timed      = (r_state == S_COUNTDOWN) || (r_state == S_FIGHT) ||
                   (r_state == S_P1_WIN) || (r_state == S_P2_WIN) || (r_state == S_EQ);
    w_wrap       = w_timed && (r_presc == PW'(TICK_DIV - 1));
    w_last       = w_wrap && (r_seconds == SW'(1));

    // Post-hit health, saturating at zero; only consumed in FIGHT
    w_p1_post = (bus.p2_hits && (r_p1_health != '0)) ? r_p1_health - HW'(1) : r_p1_health;
    w_p2_post = (bus.p1_hits && (r_p2_health != '0)) ? r_p2_health - HW'(1) : r_p2_health;

    if (w_timed) begin
      w_presc_nxt = w_wrap ? '0 : r_presc + PW'(1);
    end

    case (r_state)
      S_IDLE: begin
        w_p1_nxt      = HW'(MAX_HEALTH);
        w_p2_nxt      = HW'(MAX_HEALTH);
        w_seconds_nxt = '0;
        if (w_start_rise) begin
          w_state_nxt   = S_COUNTDOWN;
          w_seconds_nxt = SW'(COUNTDOWN_S);
        end
      end

      S_COUNTDOWN: begin
        if (w_last) begin
          w_state_nxt   = S_FIGHT;
          w_seconds_nxt = SW'(FIGHT_S);
          w_p1_nxt      = HW'(MAX_HEALTH);
          w_p2_nxt      = HW'(MAX_HEALTH);
        end else if (w_wrap) begin
          w_seconds_nxt = r_seconds - SW'(1);
        end
      end

      S_FIGHT: begin
        w_p1_nxt = w_p1_post;
        w_p2_nxt = w_p2_post;
        if ((w_p1_post == '0) && (w_p2_post == '0)) begin
          w_state_nxt   = S_EQ;
          w_seconds_nxt = SW'(RESULT_S);
        end else if (w_p2_post == '0) begin
          w_state_nxt   = S_P1_WIN;
          w_seconds_nxt = SW'(RESULT_S);
        end else if (w_p1_post == '0) begin
          w_state_nxt   = S_P2_WIN;
          w_seconds_nxt = SW'(RESULT_S);
        end else if (w_last) begin
          // Time-out: hits of this cycle are already folded into the comparison
          w_seconds_nxt = SW'(RESULT_S);
          if (w_p1_post > w_p2_post) begin
            w_state_nxt = S_P1_WIN;
          end else if (w_p2_post > w_p1_post) begin
            w_state_nxt = S_P2_WIN;
          end else begin
            w_state_nxt = S_EQ;
          end
        end else if (w_wrap) begin
          w_seconds_nxt = r_seconds - SW'(1);
        end
      end

      S_P1_WIN, S_P2_WIN, S_EQ: begin
        if (w_start_rise || w_last) begin
          w_state_nxt   = S_IDLE;
          w_seconds_nxt = '0;
          w_p1_nxt      = HW'(MAX_HEALTH);
          w_p2_nxt      = HW'(MAX_HEALTH);
        end else if (w_wrap) begin
          w_seconds_nxt = r_seconds - SW'(1);
        end
      end

      default: begin
        w_state_nxt   = S_IDLE;
        w_seconds_nxt = '0;
        w_p1_nxt      = HW'(MAX_HEALTH);
        w_p2_nxt      = HW'(MAX_HEALTH);
      end
    endcase

    // Every phase starts with a full-length first second
    if (w_state_nxt != r_state) begin
      w_presc_nxt = '0;
    end
  end

  assign bus.game_state   = r_state;
  assign bus.p1_health    = r_p1_health;
  assign bus.p2_health    = r_p2_health;
  assign bus.seconds_left = r_seconds;
  assign bus.tick         = r_tick;

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: directed vector table, hand-written match scenarios
// and random stimulus, all checked against a cycle-level behavioural match model.
module tb_game_controller;

  localparam int unsigned TICK_DIV    = 4;
  localparam int unsigned COUNTDOWN_S = 3;
  localparam int unsigned FIGHT_S     = 5;
  localparam int unsigned RESULT_S    = 2;
  localparam int unsigned MAX_HEALTH  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  game_if bus();

  game_controller #(
    .TICK_DIV(TICK_DIV), .COUNTDOWN_S(COUNTDOWN_S), .FIGHT_S(FIGHT_S),
    .RESULT_S(RESULT_S), .MAX_HEALTH(MAX_HEALTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: phase, healths, seconds, cycles spent in the current phase
  int m_state, m_p1, m_p2, m_sec, m_cnt;
  bit m_sq, m_tick;

  typedef struct {
    bit r, s, h1, h2;
    int n;
    int st, p1, p2, sec;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic enter(input int ns);
    m_state = ns;
    if (ns == 0) begin
      m_p1 = MAX_HEALTH; m_p2 = MAX_HEALTH; m_sec = 0;
    end else if (ns == 1) begin
      m_sec = COUNTDOWN_S;
    end else if (ns == 2) begin
      m_sec = FIGHT_S; m_p1 = MAX_HEALTH; m_p2 = MAX_HEALTH;
    end else begin
      m_sec = RESULT_S;
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit h1, input bit h2);
    bit rise, timed, tk;
    int prev, a, b;
    if (r) begin
      m_state = 0; m_p1 = MAX_HEALTH; m_p2 = MAX_HEALTH; m_sec = 0;
      m_cnt = 0; m_sq = 0; m_tick = 0;
      return;
    end
    rise  = s && !m_sq;
    m_sq  = s;
    timed = (m_state >= 1 && m_state <= 5);
    // A second elapses on every TICK_DIV-th cycle spent in a timed phase
    tk    = timed && ((m_cnt % TICK_DIV) == TICK_DIV - 1);
    prev  = m_state;
    case (m_state)
      0: if (rise) enter(1);
      1: if (tk) begin
           if (m_sec == 1) enter(2); else m_sec--;
         end
      2: begin
        a = (h2 && m_p1 > 0) ? m_p1 - 1 : m_p1;
        b = (h1 && m_p2 > 0) ? m_p2 - 1 : m_p2;
        m_p1 = a; m_p2 = b;
        if (a == 0 && b == 0) enter(5);
        else if (b == 0) enter(3);
        else if (a == 0) enter(4);
        else if (tk && m_sec == 1) enter(a > b ? 3 : (b > a ? 4 : 5));
        else if (tk) m_sec--;
      end
      default: begin
        if (rise || (tk && m_sec == 1)) enter(0);
        else if (tk) m_sec--;
      end
    endcase
    m_tick = tk;
    if (m_state != prev) m_cnt = 0;
    else if (timed) m_cnt++;
  endtask

  // One clock: drive inputs, advance model, sample DUT after the edge and compare
  task automatic cyc(input bit r, input bit s, input bit h1, input bit h2);
    logic [16:0] act, exp;
    rst = r; bus.start = s; bus.p1_hits = h1; bus.p2_hits = h2;
    model_step(r, s, h1, h2);
    @(posedge clk);
    #1;
    act = {bus.game_state, bus.p1_health, bus.p2_health, bus.seconds_left, bus.tick};
    exp = {3'(m_state), 3'(m_p1), 3'(m_p2), 7'(m_sec), 1'(m_tick)};
    chk("model", int'(act), int'(exp));
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0);
  endtask

  task automatic chk_out(input string name, input int st, input int p1, input int p2, input int sec);
    chk({name, ".state"}, int'(bus.game_state), st);
    chk({name, ".p1"}, int'(bus.p1_health), p1);
    chk({name, ".p2"}, int'(bus.p2_health), p2);
    chk({name, ".sec"}, int'(bus.seconds_left), sec);
  endtask

  task automatic add(input bit r, input bit s, input bit h1, input bit h2, input int n,
                     input int st, input int p1, input int p2, input int sec);
    vec_t v;
    v.r = r; v.s = s; v.h1 = h1; v.h2 = h2; v.n = n;
    v.st = st; v.p1 = p1; v.p2 = p2; v.sec = sec;
    tbl.push_back(v);
  endtask

  task automatic start_fight();
    cyc(0, 1, 0, 0);
    idle(12);
    chk("enter_fight", int'(bus.game_state), 2);
  endtask

  initial begin
    bit s_lvl;
    rst = 1'b1; bus.start = 1'b0; bus.p1_hits = 1'b0; bus.p2_hits = 1'b0;

    //  r  s  h1 h2  n    st p1 p2 sec
    add(1, 0, 0, 0,  2,   0, 3, 3, 0);
    add(0, 0, 0, 0,  1,   0, 3, 3, 0);
    add(0, 1, 0, 0,  1,   1, 3, 3, 3);
    add(0, 1, 1, 0,  1,   1, 3, 3, 3);
    add(0, 0, 0, 0,  2,   1, 3, 3, 3);
    add(0, 0, 0, 0,  1,   1, 3, 3, 2);
    add(0, 0, 0, 0,  8,   2, 3, 3, 5);
    add(0, 0, 1, 0,  1,   2, 3, 2, 5);
    add(0, 0, 1, 0,  1,   2, 3, 1, 5);
    add(0, 0, 1, 0,  1,   3, 3, 0, 2);
    add(0, 0, 0, 1,  1,   3, 3, 0, 2);
    add(0, 0, 0, 0,  6,   3, 3, 0, 1);
    add(0, 0, 0, 0,  1,   0, 3, 3, 0);
    add(0, 0, 1, 1,  1,   0, 3, 3, 0);
    add(0, 1, 0, 0,  1,   1, 3, 3, 3);
    add(0, 0, 0, 0, 12,   2, 3, 3, 5);
    add(0, 0, 0, 1,  1,   2, 2, 3, 5);
    add(0, 0, 0, 0, 19,   4, 2, 3, 2);
    add(0, 1, 0, 0,  1,   0, 3, 3, 0);
    add(0, 1, 0, 0,  3,   0, 3, 3, 0);
    add(0, 0, 0, 0,  1,   0, 3, 3, 0);

    foreach (tbl[i]) begin
      repeat (tbl[i].n) cyc(tbl[i].r, tbl[i].s, tbl[i].h1, tbl[i].h2);
      chk_out($sformatf("vec%0d", i), tbl[i].st, tbl[i].p1, tbl[i].p2, tbl[i].sec);
    end

    // Double KO from 1/1
    start_fight();
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
    chk_out("dko_pre", 2, 1, 1, 5);
    cyc(0, 0, 1, 1);
    chk_out("dko", 5, 0, 0, 2);
    idle(8);
    chk("dko_idle", int'(bus.game_state), 0);

    // Time-out with equal health
    start_fight();
    idle(20);
    chk_out("timeout_eq", 5, 3, 3, 2);
    idle(8);

    // Hit on the final-tick cycle decides the time-out
    start_fight();
    idle(19);
    cyc(0, 0, 1, 0);
    chk_out("last_tick_hit", 3, 3, 2, 2);
    idle(8);

    // Reset mid-fight, then the prescaler restarts from zero
    start_fight();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);
    idle(5);
    chk_out("pre_reset", 2, 1, 2, 3);
    cyc(1, 0, 0, 0);
    chk_out("mid_reset", 0, 3, 3, 0);
    cyc(0, 1, 0, 0);
    idle(3);
    chk_out("cd_after_reset", 1, 3, 3, 3);
    cyc(0, 0, 0, 0);
    chk_out("cd_first_tick", 1, 3, 3, 2);
    chk("cd_tick_pulse", int'(bus.tick), 1);
    cyc(1, 0, 0, 0);

    // Random traffic against the model
    s_lvl = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 29) == 0) s_lvl = ~s_lvl;
      cyc(($urandom_range(0, 499) == 0), s_lvl,
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
